// File: rtl/pll_sup_pkg.sv
// Shared encodings for the PLL lock supervisor: FSM states, retry-counter width, sizing helper.
// Pure declarations; no latency, no backpressure.
package pll_sup_pkg;

  localparam int RETRY_W = 3;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cdc_bit_sync.sv
// Single-bit multi-flop synchronizer into the clk domain, cleared to 0 by rst.
// Latency: STAGES clk edges; no backpressure.
module cdc_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: holds the PLL in reset, waits for lock with timeout and bounded retries, releases sys_rst after a stable-lock window.
// Latency: sys_rst deasserts SYNC_STAGES + LOCK_STABLE_CYC + 1 cycles after pll_lock rises; no backpressure.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_HOLD_CYC     = 64,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int MAX_RETRY        = 4,
  parameter int SYNC_STAGES      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_lock,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               lock_lost,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int CNT_W = $clog2(max3(RST_HOLD_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC) + 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

  logic               lock_s;
  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [RETRY_W-1:0] retry_nxt;
  logic               pll_rst_nxt, sys_rst_nxt, ready_nxt, lock_lost_nxt, fail_nxt;

  cdc_bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HOLD;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      pll_rst   <= pll_rst_nxt;
      sys_rst   <= sys_rst_nxt;
      ready     <= ready_nxt;
      lock_lost <= lock_lost_nxt;
      fail      <= fail_nxt;
    end
  end

  // Outputs are decoded from the next state so they change in the same edge as the state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    case (state)
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          retry_nxt = retry_cnt + 1'b1;
          cnt_nxt   = '0;
          state_nxt = (retry_nxt == RETRY_LIMIT) ? FAIL : HOLD;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
      end
      FAIL: begin
        cnt_nxt = '0;
      end
      default: begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
      end
    endcase

    pll_rst_nxt   = (state_nxt == HOLD) || (state_nxt == FAIL);
    sys_rst_nxt   = (state_nxt != RUN);
    ready_nxt     = (state_nxt == RUN);
    fail_nxt      = (state_nxt == FAIL);
    lock_lost_nxt = (state == RUN) && (state_nxt == HOLD);
  end

endmodule
